display_timing_ctrl: RTL and testbench
======================================

// Module: display_timing_ctrl
// PURPOSE
//  Frame-level raster sequencer for the VGA display path. It owns the horizontal and vertical counters
//  and runs a 4-phase FSM (SYNC/BACK/ACTIVE/FRONT) on each axis. It produces hsync/vsync, the video_on
//  window, character-cell addresses haddr/vaddr and line/frame strobes for the pixel fetch logic.
//  It runs at 2x pixel clock: 1600 clk per line = 800 pixels.
// PARAMETERS
//  H_SYNC   192   clk cycles hsync low (line starts here, hcount 0)
//  H_BACK    96   back porch cycles; active region begins at hcount 288
//  H_ACTIVE 1280  active cycles
//  H_FRONT   32   front porch cycles; H_TOTAL = sum = 1600
//  V_SYNC     2   lines vsync low; V_BACK 33, V_ACTIVE 480, V_FRONT 10; V_TOTAL 525
//  H_DIV     10   active clk cycles per haddr step (1280/10 = 128 cells)
//  V_DIV      4   active lines per vaddr step (480/4 = 120 rows)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  enable       in   1   1: timing advances; 0: every register holds
//  hsync        out  1   active-low horizontal sync
//  vsync        out  1   active-low vertical sync
//  video_on     out  1   1 when both axes are in ACTIVE
//  haddr        out  7   cell column; valid while video_on
//  vaddr        out  7   cell row; valid while video_on
//  line_start   out  1   1-cycle pulse when hcount enters 0
//  frame_start  out  1   1-cycle pulse when (hcount,vcount) enters (0,0)
//  hphase       out  2   current horizontal phase (debug/fetch prefetch)
// BEHAVIOUR
//  - All outputs are registered and aligned with the counters: the cycle in which hcount==N shows
//    the outputs for N. There is no extra pipeline latency.
//  - Reset values: hcount=0, vcount=0, hphase=SYNC, vphase=SYNC, hsync=0, vsync=0, video_on=0,
//    haddr=0, vaddr=0, hdiv=0, vdiv=0, line_start=0, frame_start=0.
//  - hcount counts 0..H_TOTAL-1 and wraps to 0. On that wrap, vcount increments, 0..V_TOTAL-1, and wraps.
//  - H FSM: SYNC->BACK at hcount=H_SYNC; BACK->ACTIVE at H_SYNC+H_BACK; ACTIVE->FRONT at
//    H_SYNC+H_BACK+H_ACTIVE; FRONT->SYNC at wrap. The V FSM uses the same scheme on vcount.
//    Transitions are taken only on line wrap.
//  - hsync=0 iff hphase==SYNC; vsync=0 iff vphase==SYNC; video_on = (hphase==ACTIVE)&&(vphase==ACTIVE).
//  - haddr/hdiv: both clear to 0 when hphase enters ACTIVE. On each active cycle, hdiv==H_DIV-1 sets
//    hdiv->0 and haddr+1 (mod 128); otherwise hdiv+1. haddr reads 127 on the last cell and wraps to 0
//    on the last active edge.
//  - vaddr/vdiv: both clear at frame wrap. At the end of each line with vphase==ACTIVE,
//    vdiv==V_DIV-1 sets vdiv->0 and vaddr+1 (mod 128); otherwise vdiv+1.
//  - line_start/frame_start go high only in the cycle after an enabled wrap edge. They are never set
//    by reset.
//  - With enable=0, all state holds, the pulses drop to 0, and the outputs are otherwise frozen.
//    Resuming continues from the held hcount.
//  - Reset mid-line has priority over enable and returns all registers to reset values next edge.
//  - Width rules: hcount is 11 bits and vcount is 10 bits. All comparisons use the full width, with no
//    truncation.
// STRUCTURE
//  - Package display_timing_pkg holds: phase typedef (SYNC=2'd0, BACK=2'd1, ACTIVE=2'd2, FRONT=2'd3),
//    default timing constants, and HADDR_W=7 / VADDR_W=7.
//  - Sub-module timing_axis_counter (params SYNC/BACK/ACTIVE/FRONT, WIDTH) is instantiated twice:
//    horizontal with advance=enable, vertical with advance=enable&&h_wrap. Each outputs count, phase
//    and wrap.
//  - The top level holds the haddr/vaddr dividers, sync/video_on decode and the strobes.
// TESTING
//  - Reset then 1600 enabled cycles -> hsync=0 at hcount 0..191 and 1 at 192..1599; line_start
//    pulses at cycle 1600 only.
//  - Active-line scan -> video_on rises at hcount 288 and falls at 1568. haddr is 0 at 288,
//    1 at 298, and 127 at 1558..1567.
//  - Full frame (840000 cycles) -> vsync low for lines 0..1; vaddr 0 on lines 35..38 and 119 on
//    lines 511..514; frame_start pulses once at wrap.
//  - enable=0 for 50 cycles at hcount=500 -> all outputs are constant and no pulses occur. Resuming
//    gives hcount=501 on the next edge.
//  - reset asserted at hcount=900, vcount=200 -> next cycle hcount=0, vcount=0, haddr=0, video_on=0,
//    hsync=0, and no frame_start pulse.
//  - Simultaneous line and frame wrap -> line_start and frame_start are both high in the same
//    single cycle.

Source files
------------

// File: rtl/display_timing_pkg.sv
// Shared phase encoding, default VGA raster timing and widths
// for the display timing sequencer.
package display_timing_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_e;

    localparam int H_SYNC_C   = 192;
    localparam int H_BACK_C   = 96;
    localparam int H_ACTIVE_C = 1280;
    localparam int H_FRONT_C  = 32;

    localparam int V_SYNC_C   = 2;
    localparam int V_BACK_C   = 33;
    localparam int V_ACTIVE_C = 480;
    localparam int V_FRONT_C  = 10;

    localparam int H_DIV_C = 10;
    localparam int V_DIV_C = 4;

    localparam int HCNT_W  = 11;
    localparam int VCNT_W  = 10;
    localparam int HADDR_W = 7;
    localparam int VADDR_W = 7;

endpackage

// File: rtl/display_timing_ctrl_axis.sv
// One raster axis: wrapping counter plus SYNC/BACK/ACTIVE/FRONT phase,
// both registered so the phase is aligned with the count it belongs to.
module timing_axis_counter
    import display_timing_pkg::*;
#(
    parameter int SYNC   = H_SYNC_C,
    parameter int BACK   = H_BACK_C,
    parameter int ACTIVE = H_ACTIVE_C,
    parameter int FRONT  = H_FRONT_C,
    parameter int WIDTH  = HCNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance_i,
    output logic [WIDTH-1:0] count_o,
    output phase_e           phase_o,
    output phase_e           phase_nxt_o,
    output logic             wrap_o
);

    localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] B0   = WIDTH'(SYNC);
    localparam logic [WIDTH-1:0] A0   = WIDTH'(SYNC + BACK);
    localparam logic [WIDTH-1:0] F0   = WIDTH'(SYNC + BACK + ACTIVE);

    logic [WIDTH-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    always_comb begin
        wrap_o  = advance_i && (count_q == LAST);
        count_d = count_q;
        phase_d = phase_q;
        if (advance_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
            if (count_d == '0)
                phase_d = PH_SYNC;
            else if (count_d == B0)
                phase_d = PH_BACK;
            else if (count_d == A0)
                phase_d = PH_ACTIVE;
            else if (count_d == F0)
                phase_d = PH_FRONT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= PH_SYNC;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count_o     = count_q;
    assign phase_o     = phase_q;
    assign phase_nxt_o = phase_d;

endmodule

// File: rtl/display_timing_ctrl.sv
// VGA raster sequencer: H/V axis counters, sync and video window decode,
// character-cell address dividers and line/frame strobes.
module display_timing_ctrl
    import display_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_C,
    parameter int H_BACK   = H_BACK_C,
    parameter int H_ACTIVE = H_ACTIVE_C,
    parameter int H_FRONT  = H_FRONT_C,
    parameter int V_SYNC   = V_SYNC_C,
    parameter int V_BACK   = V_BACK_C,
    parameter int V_ACTIVE = V_ACTIVE_C,
    parameter int V_FRONT  = V_FRONT_C,
    parameter int H_DIV    = H_DIV_C,
    parameter int V_DIV    = V_DIV_C
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [HADDR_W-1:0] haddr,
    output logic [VADDR_W-1:0] vaddr,
    output logic               line_start,
    output logic               frame_start,
    output logic [1:0]         hphase
);

    localparam int HDIV_W = (H_DIV > 1) ? $clog2(H_DIV) : 1;
    localparam int VDIV_W = (V_DIV > 1) ? $clog2(V_DIV) : 1;
    localparam int V_TOT  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [HCNT_W-1:0] H_ENTER   = HCNT_W'(H_SYNC + H_BACK - 1);
    localparam logic [VCNT_W-1:0] V_LAST    = VCNT_W'(V_TOT - 1);
    localparam logic [HDIV_W-1:0] HDIV_LAST = HDIV_W'(H_DIV - 1);
    localparam logic [VDIV_W-1:0] VDIV_LAST = VDIV_W'(V_DIV - 1);

    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    phase_e            hph, hph_nxt, vph, vph_nxt;
    logic              h_wrap, v_wrap, v_adv;

    assign v_adv = enable && h_wrap;

    timing_axis_counter #(
        .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE),
        .FRONT(H_FRONT), .WIDTH(HCNT_W)
    ) u_h (
        .clk(clk), .reset(reset), .advance_i(enable),
        .count_o(hcount), .phase_o(hph),
        .phase_nxt_o(hph_nxt), .wrap_o(h_wrap)
    );

    timing_axis_counter #(
        .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE),
        .FRONT(V_FRONT), .WIDTH(VCNT_W)
    ) u_v (
        .clk(clk), .reset(reset), .advance_i(v_adv),
        .count_o(vcount), .phase_o(vph),
        .phase_nxt_o(vph_nxt), .wrap_o(v_wrap)
    );

    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               video_on_q, video_on_d;
    logic [HADDR_W-1:0] haddr_q, haddr_d;
    logic [VADDR_W-1:0] vaddr_q, vaddr_d;
    logic [HDIV_W-1:0]  hdiv_q, hdiv_d;
    logic [VDIV_W-1:0]  vdiv_q, vdiv_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    // Decode from next-state phases so outputs line up with the counters.
    always_comb begin
        hsync_d       = (hph_nxt != PH_SYNC);
        vsync_d       = (vph_nxt != PH_SYNC);
        video_on_d    = (hph_nxt == PH_ACTIVE) && (vph_nxt == PH_ACTIVE);
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && (vcount == V_LAST);
        haddr_d       = haddr_q;
        hdiv_d        = hdiv_q;
        vaddr_d       = vaddr_q;
        vdiv_d        = vdiv_q;

        if (enable && hcount == H_ENTER) begin
            haddr_d = '0;
            hdiv_d  = '0;
        end else if (enable && hph == PH_ACTIVE) begin
            if (hdiv_q == HDIV_LAST) begin
                hdiv_d  = '0;
                haddr_d = haddr_q + 1'b1;
            end else begin
                hdiv_d = hdiv_q + 1'b1;
            end
        end

        if (v_wrap) begin
            vaddr_d = '0;
            vdiv_d  = '0;
        end else if (h_wrap && vph == PH_ACTIVE) begin
            if (vdiv_q == VDIV_LAST) begin
                vdiv_d  = '0;
                vaddr_d = vaddr_q + 1'b1;
            end else begin
                vdiv_d = vdiv_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            video_on_q    <= 1'b0;
            haddr_q       <= '0;
            vaddr_q       <= '0;
            hdiv_q        <= '0;
            vdiv_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            haddr_q       <= haddr_d;
            vaddr_q       <= vaddr_d;
            hdiv_q        <= hdiv_d;
            vdiv_q        <= vdiv_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign haddr       = haddr_q;
    assign vaddr       = vaddr_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign hphase      = hph;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Directed bench for display_timing_ctrl: default horizontal timing,
// a short 15-line vertical raster so whole frames fit in a short run.
module tb_display_timing_ctrl;

    localparam int H_TOT = 1600;
    localparam int V_TOT = 15;
    localparam int F_TOT = H_TOT * V_TOT;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       hsync, vsync, video_on;
    logic [6:0] haddr, vaddr;
    logic       line_start, frame_start;
    logic [1:0] hphase;

    always #5 clk = ~clk;

    display_timing_ctrl #(
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(8), .V_FRONT(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .haddr(haddr), .vaddr(vaddr),
        .line_start(line_start), .frame_start(frame_start),
        .hphase(hphase)
    );

    typedef struct packed {
        logic       hs, vs, vo;
        logic [6:0] ha, va;
        logic       ls, fs;
        logic [1:0] ph;
    } exp_t;

    typedef struct {
        int   f;
        int   v;
        int   h;
        exp_t e;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   pos;
    vec_t tbl[$];

    function automatic exp_t mk(input int hs, vs, vo, ha, va, ls, fs, ph);
        exp_t e;
        e.hs = hs[0];
        e.vs = vs[0];
        e.vo = vo[0];
        e.ha = ha[6:0];
        e.va = va[6:0];
        e.ls = ls[0];
        e.fs = fs[0];
        e.ph = ph[1:0];
        return e;
    endfunction

    function automatic int at(input int f, v, h);
        return f * F_TOT + v * H_TOT + h;
    endfunction

    task automatic add(input int f, v, h, hs, vs, vo, ha, va, ls, fs, ph);
        vec_t t;
        t.f = f;
        t.v = v;
        t.h = h;
        t.e = mk(hs, vs, vo, ha, va, ls, fs, ph);
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input exp_t e);
        exp_t a;
        a = {hsync, vsync, video_on, haddr, vaddr, line_start, frame_start, hphase};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s pos=%0d got hs=%0b vs=%0b vo=%0b ha=%0d va=%0d ls=%0b fs=%0b ph=%0d want hs=%0b vs=%0b vo=%0b ha=%0d va=%0d ls=%0b fs=%0b ph=%0d",
                     nm, pos, a.hs, a.vs, a.vo, a.ha, a.va, a.ls, a.fs, a.ph,
                     e.hs, e.vs, e.vo, e.ha, e.va, e.ls, e.fs, e.ph);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (enable) pos++;
        @(negedge clk);
    endtask

    task automatic go_to(input int target);
        while (pos < target) tick();
    endtask

    exp_t hold_e;

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        pos    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pos   = 0;

        //  f  v  h      hs vs vo ha  va ls fs ph
        add(0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 0, 191,   0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 0, 192,   1, 0, 0, 0,  0, 0, 0, 1);
        add(0, 0, 288,   1, 0, 0, 0,  0, 0, 0, 2);
        add(0, 0, 298,   1, 0, 0, 1,  0, 0, 0, 2);
        add(0, 0, 1568,  1, 0, 0, 0,  0, 0, 0, 3);
        add(0, 0, 1599,  1, 0, 0, 0,  0, 0, 0, 3);
        add(0, 1, 0,     0, 0, 0, 0,  0, 1, 0, 0);
        add(0, 1, 1,     0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 2, 0,     0, 1, 0, 0,  0, 1, 0, 0);
        add(0, 5, 287,   1, 1, 0, 0,  0, 0, 0, 1);
        add(0, 5, 288,   1, 1, 1, 0,  0, 0, 0, 2);
        add(0, 5, 297,   1, 1, 1, 0,  0, 0, 0, 2);
        add(0, 5, 298,   1, 1, 1, 1,  0, 0, 0, 2);
        add(0, 5, 1557,  1, 1, 1, 126, 0, 0, 0, 2);
        add(0, 5, 1558,  1, 1, 1, 127, 0, 0, 0, 2);
        add(0, 5, 1567,  1, 1, 1, 127, 0, 0, 0, 2);
        add(0, 5, 1568,  1, 1, 0, 0,  0, 0, 0, 3);
        add(0, 8, 300,   1, 1, 1, 1,  0, 0, 0, 2);
        add(0, 9, 300,   1, 1, 1, 1,  1, 0, 0, 2);
        add(0, 12, 1000, 1, 1, 1, 71, 1, 0, 0, 2);
        add(0, 13, 300,  1, 1, 0, 1,  2, 0, 0, 2);
        add(0, 14, 1599, 1, 1, 0, 0,  2, 0, 0, 3);
        add(1, 0, 0,     0, 0, 0, 0,  0, 1, 1, 0);
        add(1, 0, 1,     0, 0, 0, 0,  0, 0, 0, 0);

        foreach (tbl[i]) begin
            go_to(at(tbl[i].f, tbl[i].v, tbl[i].h));
            check($sformatf("tbl%0d", i), tbl[i].e);
        end

        // Freeze mid-active for 50 cycles, then resume
        hold_e = mk(1, 0, 0, 21, 0, 0, 0, 2);
        go_to(at(1, 0, 500));
        check("pre_hold", hold_e);
        enable = 1'b0;
        repeat (50) begin
            tick();
            check("hold", hold_e);
        end
        enable = 1'b1;
        tick();
        check("resume_501", hold_e);
        go_to(at(1, 0, 507));
        check("h507", mk(1, 0, 0, 21, 0, 0, 0, 2));
        tick();
        check("h508", mk(1, 0, 0, 22, 0, 0, 0, 2));

        // Freeze on the last cycle of a line: no strobe until resumed
        hold_e = mk(1, 0, 0, 0, 0, 0, 0, 3);
        go_to(at(1, 0, 1599));
        check("pre_wrap_hold", hold_e);
        enable = 1'b0;
        repeat (3) begin
            tick();
            check("wrap_hold", hold_e);
        end
        enable = 1'b1;
        tick();
        check("wrap_resume", mk(0, 0, 0, 0, 0, 1, 0, 0));
        tick();
        check("wrap_resume_next", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset mid-line, with enable low to show reset wins
        go_to(at(1, 7, 900));
        check("pre_reset", mk(1, 1, 1, 61, 0, 0, 0, 2));
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        pos    = 0;
        check("reset_mid", mk(0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check("post_reset_1", mk(0, 0, 0, 0, 0, 0, 0, 0));
        go_to(at(0, 1, 0));
        check("post_reset_line", mk(0, 0, 0, 0, 0, 1, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
